pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline register with bubble counter; PIPE_SKID_EN adds a skid entry
module pipe_stage_reg #(
  parameter int DATA_W   = 32,
  parameter int CTRL_W   = 5,
  parameter int ADDR_W   = 5,
  parameter int NOP_CTRL = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [ADDR_W-1:0] waddr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] op_a_o,
  output logic [DATA_W-1:0] op_b_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [ADDR_W-1:0] waddr_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  localparam int BEAT_W = CTRL_W + ADDR_W + 2 * DATA_W;
  localparam logic [CTRL_W-1:0] NOP = CTRL_W'(NOP_CTRL);
  // An empty slot always holds the NOP beat so outputs read as a bubble.
  localparam logic [BEAT_W-1:0] IDLE_BEAT = {NOP, {(ADDR_W + 2 * DATA_W){1'b0}}};

  logic [BEAT_W-1:0] in_beat;
  logic [BEAT_W-1:0] main_q;
  logic              in_xfer;
  logic              out_xfer;

  assign in_beat  = {ctrl_i, waddr_i, op_b_i, op_a_i};
  assign in_xfer  = in_valid_i && in_ready_o;
  assign out_xfer = out_valid_o && out_ready_i;
  assign {ctrl_o, waddr_o, op_b_o, op_a_o} = main_q;

`ifdef PIPE_SKID_EN
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_MAIN  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              ready_q;
  logic [BEAT_W-1:0] skid_q;

  assign out_valid_o = (state != ST_EMPTY);
  assign in_ready_o  = ready_q || flush_i;

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (in_xfer) state_nxt = ST_MAIN;
        ST_MAIN: begin
          if (in_xfer && !out_xfer)      state_nxt = ST_FULL;
          else if (!in_xfer && out_xfer) state_nxt = ST_EMPTY;
        end
        ST_FULL:  if (out_xfer) state_nxt = ST_MAIN;
        default:  state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_EMPTY;
      ready_q <= 1'b1;
      main_q  <= IDLE_BEAT;
      skid_q  <= IDLE_BEAT;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt != ST_FULL);
      if (flush_i) begin
        main_q <= IDLE_BEAT;
        skid_q <= IDLE_BEAT;
      end else begin
        case (state)
          ST_EMPTY: if (in_xfer) main_q <= in_beat;
          ST_MAIN: begin
            if (in_xfer && out_xfer) main_q <= in_beat;
            else if (in_xfer)        skid_q <= in_beat;
            else if (out_xfer)       main_q <= IDLE_BEAT;
          end
          ST_FULL: begin
            if (out_xfer) begin
              main_q <= skid_q;
              skid_q <= IDLE_BEAT;
            end
          end
          default: begin
            main_q <= IDLE_BEAT;
            skid_q <= IDLE_BEAT;
          end
        endcase
      end
    end
  end
`else
  logic valid_q;

  assign out_valid_o = valid_q;
  assign in_ready_o  = flush_i || !valid_q || out_ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      main_q  <= IDLE_BEAT;
    end else if (flush_i) begin
      valid_q <= 1'b0;
      main_q  <= IDLE_BEAT;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
      main_q  <= in_beat;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
      main_q  <= IDLE_BEAT;
    end
  end
`endif

  // Saturating; deliberately unaffected by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_o <= '0;
    end else if (!out_valid_o && (bubble_cnt_o != {CNT_W{1'b1}})) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

endmodule
